// File: rtl/sprite_motion_engine_pkg.sv
// Shared definitions for the sprite motion engine: direction codes, sprite
// indices, default playfield geometry and default start cells.
package sprite_motion_engine_pkg;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam int SPR_PACMAN = 0;
  localparam int SPR_BLINKY = 1;
  localparam int SPR_PINKY  = 2;
  localparam int SPR_INKY   = 3;
  localparam int SPR_CLYDE  = 4;

  localparam int DEF_NUM_SPRITES = 5;
  localparam int DEF_GRID_W      = 80;
  localparam int DEF_GRID_H      = 50;
  localparam int DEF_CELL        = 16;
  localparam int DEF_ORIGIN_X    = 336;
  localparam int DEF_ORIGIN_Y    = 27;

  // Sprite 0 occupies the least significant field.
  localparam logic [34:0] DEF_RESET_COLS = {7'd67, 7'd43, 7'd6, 7'd66, 7'd64};
  localparam logic [29:0] DEF_RESET_ROWS = {6'd2, 6'd23, 6'd25, 6'd6, 6'd17};

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_UPDATE,
    S_DONE
  } state_t;

endpackage

// File: rtl/sprite_motion_engine_grid_to_pixel.sv
// Combinational grid-cell to pixel-centre converter; results wrap to the
// output widths.
module grid_to_pixel
  import sprite_motion_engine_pkg::*;
#(
  parameter int CW       = 7,
  parameter int RW       = 6,
  parameter int CELL     = DEF_CELL,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic [CW-1:0] col,
  input  logic [RW-1:0] row,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  assign x = XW'(ORIGIN_X + int'(col) * CELL + CELL / 2 - 1);
  assign y = YW'(ORIGIN_Y + int'(row) * CELL + CELL / 2 - 1);

endmodule

// File: rtl/sprite_motion_engine.sv
// Walks every sprite once per step, asks the map which moves are legal and
// advances each sprite by at most one cell, wrapping at the grid edges.
module sprite_motion_engine
  import sprite_motion_engine_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int GRID_W      = DEF_GRID_W,
  parameter int GRID_H      = DEF_GRID_H,
  parameter int CELL        = DEF_CELL,
  parameter int ORIGIN_X    = DEF_ORIGIN_X,
  parameter int ORIGIN_Y    = DEF_ORIGIN_Y,
  parameter int XW          = 11,
  parameter int YW          = 10,
  parameter int WRAP_EN     = 1,
  parameter logic [NUM_SPRITES*$clog2(GRID_W)-1:0] RESET_COLS = DEF_RESET_COLS,
  parameter logic [NUM_SPRITES*$clog2(GRID_H)-1:0] RESET_ROWS = DEF_RESET_ROWS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step,
  input  logic [NUM_SPRITES*4-1:0]      dir,
  output logic                          busy,
  output logic                          done,
  output logic                          vm_req,
  output logic [$clog2(GRID_W)-1:0]     vm_col,
  output logic [$clog2(GRID_H)-1:0]     vm_row,
  input  logic                          vm_ack,
  input  logic [3:0]                    vm_valid,
  output logic [NUM_SPRITES*XW-1:0]     pos_x,
  output logic [NUM_SPRITES*YW-1:0]     pos_y,
  output logic [NUM_SPRITES-1:0]        moved
);

  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);
  localparam int KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SPRITES - 1);

  state_t state, state_d;
  logic start, take, apply;
  logic [KW-1:0] k;
  logic [NUM_SPRITES*4-1:0] dir_q;
  logic [3:0] vm_valid_q;

  logic [CW-1:0] col   [NUM_SPRITES];
  logic [CW-1:0] col_d [NUM_SPRITES];
  logic [RW-1:0] row   [NUM_SPRITES];
  logic [RW-1:0] row_d [NUM_SPRITES];
  logic [XW-1:0] px    [NUM_SPRITES];
  logic [YW-1:0] py    [NUM_SPRITES];

  logic [3:0] d;
  logic [CW-1:0] mv_col;
  logic [RW-1:0] mv_row;
  logic mv_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    take    = 1'b0;
    apply   = 1'b0;
    vm_req  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (step) begin
          start   = 1'b1;
          state_d = S_QUERY;
        end
      end
      S_QUERY: begin
        vm_req = 1'b1;
        if (vm_ack) begin
          take    = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        apply   = 1'b1;
        state_d = (k == K_LAST) ? S_DONE : S_QUERY;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vm_col = col[k];
  assign vm_row = row[k];

  // Candidate move for sprite k; a non-one-hot direction matches no case arm.
  always_comb begin
    d      = dir_q[{k, 2'b00} +: 4];
    mv_col = col[k];
    mv_row = row[k];
    mv_ok  = 1'b0;
    if ((d & vm_valid_q) != 4'b0000) begin
      case (d)
        DIR_RIGHT: begin
          mv_ok  = (col[k] != CW'(GRID_W - 1)) || (WRAP_EN != 0);
          mv_col = (col[k] == CW'(GRID_W - 1)) ? '0 : col[k] + 1'b1;
        end
        DIR_LEFT: begin
          mv_ok  = (col[k] != '0) || (WRAP_EN != 0);
          mv_col = (col[k] == '0) ? CW'(GRID_W - 1) : col[k] - 1'b1;
        end
        DIR_DOWN: begin
          mv_ok  = (row[k] != RW'(GRID_H - 1)) || (WRAP_EN != 0);
          mv_row = (row[k] == RW'(GRID_H - 1)) ? '0 : row[k] + 1'b1;
        end
        DIR_UP: begin
          mv_ok  = (row[k] != '0) || (WRAP_EN != 0);
          mv_row = (row[k] == '0) ? RW'(GRID_H - 1) : row[k] - 1'b1;
        end
        default: mv_ok = 1'b0;
      endcase
    end
  end

  // Next cell per sprite; the pixel converters see this so pos_* lands on
  // the same edge as the cell update (and as reset).
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      col_d[i] = col[i];
      row_d[i] = row[i];
      if (rst) begin
        col_d[i] = RESET_COLS[i*CW +: CW];
        row_d[i] = RESET_ROWS[i*RW +: RW];
      end else if (apply && mv_ok && (k == KW'(i))) begin
        col_d[i] = mv_col;
        row_d[i] = mv_row;
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pix
    grid_to_pixel #(
      .CW(CW), .RW(RW), .CELL(CELL), .ORIGIN_X(ORIGIN_X),
      .ORIGIN_Y(ORIGIN_Y), .XW(XW), .YW(YW)
    ) u_g2p (
      .col(col_d[g]),
      .row(row_d[g]),
      .x  (px[g]),
      .y  (py[g])
    );
  end

  always_ff @(posedge clk) begin
    col <= col_d;
    row <= row_d;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pos_x[i*XW +: XW] <= px[i];
      pos_y[i*YW +: YW] <= py[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      moved <= '0;
    end else begin
      if (start) begin
        k     <= '0;
        moved <= '0;
      end
      if (apply) begin
        moved[k] <= mv_ok;
        if (k != K_LAST) k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) dir_q <= dir;
    if (take)  vm_valid_q <= vm_valid;
  end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench for sprite_motion_engine with a done-triggered scoreboard;
// a second instance runs with edge wrapping disabled.
`timescale 1ns/1ps
module tb_sprite_motion_engine;
  import sprite_motion_engine_pkg::*;

  logic clk = 1'b0;
  logic rst, step, vm_ack;
  logic [19:0] dir;
  logic [3:0]  vm_valid;
  logic busy, done, vm_req, busy2, done2, vm_req2;
  logic [6:0]  vm_col, vm_col2;
  logic [5:0]  vm_row, vm_row2;
  logic [54:0] pos_x, pos_x2;
  logic [49:0] pos_y, pos_y2;
  logic [4:0]  moved, moved2;

  always #5 clk = ~clk;

  sprite_motion_engine dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .busy(busy), .done(done),
    .vm_req(vm_req), .vm_col(vm_col), .vm_row(vm_row), .vm_ack(vm_ack),
    .vm_valid(vm_valid), .pos_x(pos_x), .pos_y(pos_y), .moved(moved)
  );

  sprite_motion_engine #(
    .WRAP_EN(0),
    .RESET_COLS({7'd67, 7'd43, 7'd6, 7'd66, 7'd79}),
    .RESET_ROWS({6'd2, 6'd23, 6'd25, 6'd6, 6'd0})
  ) dut2 (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .busy(busy2), .done(done2),
    .vm_req(vm_req2), .vm_col(vm_col2), .vm_row(vm_row2), .vm_ack(vm_ack),
    .vm_valid(vm_valid), .pos_x(pos_x2), .pos_y(pos_y2), .moved(moved2)
  );

  typedef struct {
    logic [54:0] x;
    logic [49:0] y;
    logic [4:0]  mv;
    bit          c2;
    logic [10:0] x2;
    logic [9:0]  y2;
    logic        m2;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ec[5];
  int er[5];
  int e2c, e2r;
  int dly_sprite = -1;
  int dly_n = 0;
  int qn = 0;
  int q_exp_col = 0;
  int q_exp_row = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int px(input int c);
    return 336 + 16 * c + 7;
  endfunction

  function automatic int py(input int r);
    return 27 + 16 * r + 7;
  endfunction

  function automatic logic [54:0] vec_x();
    logic [54:0] v;
    for (int i = 0; i < 5; i++) v[i*11 +: 11] = 11'(px(ec[i]));
    return v;
  endfunction

  function automatic logic [49:0] vec_y();
    logic [49:0] v;
    for (int i = 0; i < 5; i++) v[i*10 +: 10] = 10'(py(er[i]));
    return v;
  endfunction

  task automatic push_exp(input logic [4:0] mv, input bit c2, input logic m2);
    exp_t e;
    e.x  = vec_x();
    e.y  = vec_y();
    e.mv = mv;
    e.c2 = c2;
    e.x2 = 11'(px(e2c));
    e.y2 = 10'(py(e2r));
    e.m2 = m2;
    sbq.push_back(e);
  endtask

  // Map responder: acks immediately except for the selected delayed sprite.
  initial begin
    int cnt;
    logic [6:0] hc;
    logic [5:0] hr;
    cnt = 0;
    hc = '0;
    hr = '0;
    vm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (vm_req) begin
        if (qn == dly_sprite) begin
          if (cnt == 0) begin
            hc = vm_col;
            hr = vm_row;
            chk("delayed query vm_col", vm_col, q_exp_col);
            chk("delayed query vm_row", vm_row, q_exp_row);
          end else begin
            chk("vm_col held", vm_col, hc);
            chk("vm_row held", vm_row, hr);
          end
        end
        if (qn != dly_sprite || cnt >= dly_n) begin
          vm_ack = 1'b1;
          qn++;
        end else begin
          vm_ack = 1'b0;
        end
        cnt++;
      end else begin
        vm_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: got done=1 with no round pending, expected none");
        end else begin
          e = sbq.pop_front();
          chk("pos_x", pos_x, e.x);
          chk("pos_y", pos_y, e.y);
          chk("moved", moved, e.mv);
          chk("done2 lockstep", done2, 1);
          if (e.c2) begin
            chk("nowrap pos_x[0]", pos_x2[10:0], e.x2);
            chk("nowrap pos_y[0]", pos_y2[9:0], e.y2);
            chk("nowrap moved[0]", moved2[0], e.m2);
          end
        end
      end
    end
  end

  task automatic run_round(input logic [19:0] d, input logic [3:0] v,
                           input int exp_cyc, input bit step_at_done);
    int n;
    dir = d;
    vm_valid = v;
    qn = 0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("busy after step", busy, 1);
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done latency", n, exp_cyc);
    step = step_at_done;
    @(negedge clk);
    step = 1'b0;
    if (step_at_done) chk("step during done ignored busy", busy, 0);
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1;
    step = 1'b0;
    dir = '0;
    vm_valid = '0;
    ec = '{64, 66, 6, 43, 67};
    er = '{17, 6, 25, 23, 2};
    e2c = 79;
    e2r = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset pos_x[0]", pos_x[10:0], 1367);
    chk("reset pos_y[0]", pos_y[9:0], 306);
    chk("reset pos_x[4]", pos_x[54:44], 1415);
    chk("reset pos_y[4]", pos_y[49:40], 66);
    chk("reset busy", busy, 0);
    chk("reset vm_req", vm_req, 0);
    chk("reset done", done, 0);
    chk("reset moved", moved, 0);
    chk("reset nowrap pos_x[0]", pos_x2[10:0], 1607);
    chk("reset nowrap pos_y[0]", pos_y2[9:0], 34);

    // Pacman right; no-wrap instance sits at col 79 and is blocked.
    ec[0] = 65;
    push_exp(5'b00001, 1'b1, 1'b0);
    run_round(20'h00001, 4'hF, 11, 1'b0);
    chk("pacman right pos_x[0]", pos_x[10:0], 1383);

    // Pacman up; no-wrap instance sits at row 0 and is blocked.
    er[0] = 16;
    push_exp(5'b00001, 1'b1, 1'b0);
    run_round(20'h00002, 4'hF, 11, 1'b0);

    // Clyde walks to the right edge, then wraps.
    for (int i = 0; i < 12; i++) begin
      ec[4] = ec[4] + 1;
      push_exp(5'b10000, 1'b0, 1'b0);
      run_round(20'h10000, 4'hF, 11, 1'b0);
    end
    ec[4] = 0;
    push_exp(5'b10000, 1'b0, 1'b0);
    run_round(20'h10000, 4'hF, 11, 1'b0);
    chk("wrap right pos_x[4]", pos_x[54:44], 343);

    // Clyde walks to the top edge, then wraps.
    for (int i = 0; i < 2; i++) begin
      er[4] = er[4] - 1;
      push_exp(5'b10000, 1'b0, 1'b0);
      run_round(20'h20000, 4'hF, 11, 1'b0);
    end
    er[4] = 49;
    push_exp(5'b10000, 1'b0, 1'b0);
    run_round(20'h20000, 4'hF, 11, 1'b0);
    chk("wrap up pos_y[4]", pos_y[49:40], 818);

    // Illegal or disallowed directions leave everything in place.
    push_exp(5'b00000, 1'b1, 1'b0);
    run_round(20'h00003, 4'hF, 11, 1'b0);
    push_exp(5'b00000, 1'b1, 1'b0);
    run_round(20'h00000, 4'hF, 11, 1'b0);
    push_exp(5'b00000, 1'b1, 1'b0);
    run_round(20'h00001, 4'hE, 11, 1'b1);

    // Every sprite moves; pinky's query is acked three cycles late.
    ec[0] = 64;
    er[1] = 7;
    er[2] = 24;
    ec[3] = 44;
    er[4] = 0;
    e2c = 78;
    dly_sprite = 2;
    dly_n = 3;
    q_exp_col = 6;
    q_exp_row = 25;
    push_exp(5'b11111, 1'b1, 1'b1);
    run_round(20'h41248, 4'hF, 14, 1'b0);

    // Reset in the middle of inky's query aborts the round.
    dly_sprite = 3;
    dly_n = 5;
    q_exp_col = 44;
    q_exp_row = 23;
    dir = 20'h00001;
    vm_valid = 4'hF;
    qn = 0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n = 0;
    while (!(vm_req && qn == 3) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reached inky query", (vm_req && qn == 3), 1);
    chk("mid-round pos_x[0]", pos_x[10:0], 1383);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ec = '{64, 66, 6, 43, 67};
    er = '{17, 6, 25, 23, 2};
    e2c = 79;
    e2r = 0;
    dly_sprite = -1;
    chk("abort pos_x", pos_x, vec_x());
    chk("abort pos_y", pos_y, vec_y());
    chk("abort busy", busy, 0);
    chk("abort vm_req", vm_req, 0);
    chk("abort moved", moved, 0);
    chk("abort vm_col", vm_col, 64);
    chk("abort vm_row", vm_row, 17);
    chk("abort nowrap busy", busy2, 0);
    chk("abort nowrap vm_req", vm_req2, 0);
    chk("abort nowrap vm_col", vm_col2, 79);
    chk("abort nowrap vm_row", vm_row2, 0);
    repeat (20) @(negedge clk);
    chk("no done after abort", done_cnt - d0, 0);

    // Normal operation resumes after the abort.
    ec[0] = 65;
    push_exp(5'b00001, 1'b1, 1'b0);
    run_round(20'h00001, 4'hF, 11, 1'b0);

    chk("scoreboard drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
